// File: rtl/generador_obstaculos.sv
`default_nettype none
// ============================================================================
//  Module      : generador_obstaculos
//  Description : Obstacle source for the runner game. Shifts a three-display
//                7-segment field toward the hero on every GAME tick, inserts
//                LFSR-chosen obstacles/bonus separated by blank gaps, counts
//                obstacles passed and advances the world counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module generador_obstaculos #(
    parameter logic [2:0] OFF           = 3'd0,
    parameter logic [2:0] WLCM          = 3'd1,
    parameter logic [2:0] CH            = 3'd2,
    parameter logic [2:0] GAME          = 3'd3,
    parameter logic [2:0] WL            = 3'd4,
    parameter logic [2:0] PA            = 3'd5,
    parameter logic [7:0] SEMILLA       = 8'hA5,  // must be nonzero
    parameter int         ESPACIO       = 2,      // blanks after each insertion, >= 1
    parameter int         OBS_POR_MUNDO = 8       // obstacles per world, 1..16
) (
    input  logic        clk_obstaculos,
    input  logic        rst_n,
    input  logic [2:0]  presente,
    output logic [20:0] display_obs,
    output logic [1:0]  mundo,
    output logic [3:0]  obs_pasados,
    output logic        cambio_mundo
);

    localparam int               GAP_W      = (ESPACIO < 2) ? 1 : $clog2(ESPACIO + 1);
    localparam logic [GAP_W-1:0] GAP_RECARGA = GAP_W'(ESPACIO);
    localparam logic [GAP_W-1:0] GAP_UNO     = GAP_W'(1);
    localparam logic [3:0]       OBS_ULTIMO  = 4'(OBS_POR_MUNDO - 1);
    localparam logic [1:0]       MUNDO_FIN   = 2'd3;

    // Segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] ALTO  = 7'b1000000;
    localparam logic [6:0] MEDIO = 7'b0000001;
    localparam logic [6:0] BAJO  = 7'b0001000;
    localparam logic [6:0] BONO  = 7'b1111111;

    logic [20:0]      display_q, display_d;
    logic [1:0]       mundo_q, mundo_d;
    logic [3:0]       obs_q, obs_d;
    logic             cambio_q, cambio_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             fb;
    logic [6:0]       patron;
    logic [6:0]       nuevo;
    logic [6:0]       saliente;
    logic             pasa;

    // Pattern choice from the LFSR value held before this tick's update
    always_comb begin
        patron = BAJO;
        case (lfsr_q[1:0])
            2'b00:   patron = ALTO;
            2'b01:   patron = MEDIO;
            2'b10:   patron = BAJO;
            default: patron = lfsr_q[7] ? BONO : BAJO;
        endcase
    end

    // Next-state logic: free-running LFSR plus per-state field/world update
    always_comb begin
        fb        = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d    = {lfsr_q[6:0], fb};
        display_d = display_q;
        mundo_d   = mundo_q;
        obs_d     = obs_q;
        gap_d     = gap_q;
        cambio_d  = 1'b0;
        nuevo     = 7'd0;
        saliente  = display_q[6:0];
        // Bonus never counts, and nothing counts once the game is won
        pasa      = (saliente != 7'd0) && (saliente != BONO) && (mundo_q != MUNDO_FIN);

        case (presente)
            GAME: begin
                if ((gap_q != '0) || (mundo_q == MUNDO_FIN)) begin
                    nuevo = 7'd0;
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_UNO;
                    end
                end else begin
                    nuevo = patron;
                    gap_d = GAP_RECARGA;
                end
                display_d = {nuevo, display_q[20:7]};
                if (pasa) begin
                    if (obs_q == OBS_ULTIMO) begin
                        obs_d    = 4'd0;
                        mundo_d  = mundo_q + 2'd1;
                        cambio_d = 1'b1;
                    end else begin
                        obs_d = obs_q + 4'd1;
                    end
                end
            end
            OFF, WLCM, CH: begin
                display_d = 21'd0;
                mundo_d   = 2'd0;
                obs_d     = 4'd0;
                gap_d     = GAP_RECARGA;
            end
            default: begin
                // PA, WL and unused encodings freeze the field
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk_obstaculos) begin
        if (!rst_n) begin
            display_q <= 21'd0;
            mundo_q   <= 2'd0;
            obs_q     <= 4'd0;
            cambio_q  <= 1'b0;
            lfsr_q    <= SEMILLA;
            gap_q     <= GAP_RECARGA;
        end else begin
            display_q <= display_d;
            mundo_q   <= mundo_d;
            obs_q     <= obs_d;
            cambio_q  <= cambio_d;
            lfsr_q    <= lfsr_d;
            gap_q     <= gap_d;
        end
    end

    assign display_obs  = display_q;
    assign mundo        = mundo_q;
    assign obs_pasados  = obs_q;
    assign cambio_mundo = cambio_q;

endmodule
`default_nettype wire
